dcache_assoc: RTL

Parametrised write-back, write-allocate data cache between the CPU memory stage (p1 interface) and the 256-bit-class data memory. It is the set-associative successor of the direct-mapped data cache. Line width, set count and associativity are generics, with tree pseudo-LRU replacement. It adds an explicit flush that writes back every dirty line.

---
 rtl/dcache_pkg.sv | 50 +++++
 rtl/dcache_plru.sv | 32 +++
 rtl/dcache_assoc.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the set-associative data cache:
// FSM state encoding, address field widths and tree pseudo-LRU math.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    REFILL,
    REFILL_OK,
    FLUSH_SCAN,
    FLUSH_WB
  } state_e;

  function automatic int offset_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_w, input int sets);
    return addr_w - offset_w(line_w) - index_w(sets);
  endfunction

  // Tree bits point towards the least recently used side.
  function automatic logic [1:0] plru_victim(input logic [2:0] p, input int ways);
    logic [1:0] v;
    v = 2'd0;
    if (ways == 2) v = {1'b0, p[0]};
    else if (ways == 4) v = p[0] ? {1'b1, p[2]} : {1'b0, p[1]};
    return v;
  endfunction

  function automatic logic [2:0] plru_update(input logic [2:0] p, input logic [1:0] w,
                                             input int ways);
    logic [2:0] n;
    n = p;
    if (ways == 2) begin
      n[0] = ~w[0];
    end else if (ways == 4) begin
      n[0] = ~w[1];
      if (!w[1]) n[1] = ~w[0];
      else n[2] = ~w[0];
    end
    return n;
  endfunction

endpackage

// File: rtl/dcache_plru.sv
// Per-set pseudo-LRU state: exposes the replacement victim of one set and
// accepts one access update per cycle.
module dcache_plru
  import dcache_pkg::*;
#(
  parameter int SETS  = 32,
  parameter int WAYS  = 2,
  parameter int IDX_W = 5,
  parameter int WAY_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_set,
  output logic [WAY_W-1:0] victim,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_set,
  input  logic [WAY_W-1:0] upd_way
);

  logic [2:0] plru_q [SETS];

  assign victim = WAY_W'(plru_victim(plru_q[rd_set], WAYS));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= 3'b000;
    end else if (upd_en) begin
      plru_q[upd_set] <= plru_update(plru_q[upd_set], 2'(upd_way), WAYS);
    end
  end

endmodule

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate set-associative data cache with PLRU replacement
// and a flush that writes back every dirty line.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 32,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [WORD_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [WORD_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic              flush_i,
  output logic              flush_done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic              mem_ack_i,
  output state_e            dbg_state_o
);

  localparam int OFF_W  = offset_w(LINE_W);
  localparam int IDX_W  = index_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
  localparam int WSEL_W = $clog2(LINE_W / WORD_W);
  localparam int BYTE_W = $clog2(WORD_W / 8);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Memory handshake: address, data and direction are held stable while
  // mem_enable_o is high; a one-cycle mem_ack_i completes the access and
  // enable drops the cycle after. Ack while enable is low is ignored.

  state_e state_q, state_d;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];

  logic [TAG_W-1:0]  p_tag;
  logic [IDX_W-1:0]  p_idx;
  logic [WSEL_W-1:0] p_wsel;
  logic              unused_addr;
  logic              req, hit, any_inv, vic_dirty, fl_dirty, fl_last;
  logic [2:0]        n_match;
  logic [WAY_W-1:0]  hit_way, inv_way, plru_vic, victim, victim_q;
  logic [WAY_W-1:0]  way_cnt_q, way_nxt, plru_way;
  logic [IDX_W-1:0]  set_cnt_q, set_nxt;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_data_q, refill_q;
  logic              flush_done_q;

  assign p_tag       = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign p_idx       = p1_addr_i[OFF_W +: IDX_W];
  assign p_wsel      = p1_addr_i[BYTE_W +: WSEL_W];
  assign unused_addr = ^p1_addr_i[BYTE_W-1:0];
  assign req         = p1_MemRead_i | p1_MemWrite_i;

  // Descending walk leaves the lowest-numbered invalid way in inv_way.
  always_comb begin
    n_match = 3'd0;
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[p_idx][w] && (tag_q[p_idx][w] == p_tag)) begin
        hit_way = WAY_W'(w);
        n_match = n_match + 3'd1;
      end
      if (!valid_q[p_idx][w]) begin
        inv_way = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
  end

  assign hit       = req && (n_match == 3'd1);
  assign victim    = any_inv ? inv_way : plru_vic;
  assign vic_dirty = valid_q[p_idx][victim] & dirty_q[p_idx][victim];
  assign fl_dirty  = valid_q[set_cnt_q][way_cnt_q] & dirty_q[set_cnt_q][way_cnt_q];
  assign fl_last   = (set_cnt_q == IDX_W'(SETS - 1)) && (way_cnt_q == WAY_W'(WAYS - 1));

  always_comb begin
    way_nxt = way_cnt_q + 1'b1;
    set_nxt = set_cnt_q;
    if (way_cnt_q == WAY_W'(WAYS - 1)) begin
      way_nxt = '0;
      set_nxt = set_cnt_q + 1'b1;
    end
  end

  assign p1_data_o    = data_q[p_idx][hit_way][p_wsel*WORD_W +: WORD_W];
  assign p1_stall_o   = (req & ~hit) | (state_q != IDLE);
  assign flush_done_o = flush_done_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign dbg_state_o  = state_q;
  assign plru_way     = (state_q == REFILL_OK) ? victim_q : hit_way;

  dcache_plru #(
    .SETS (SETS),
    .WAYS (WAYS),
    .IDX_W(IDX_W),
    .WAY_W(WAY_W)
  ) u_plru (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .rd_set (p_idx),
    .victim (plru_vic),
    .upd_en (((state_q == IDLE) && hit) || (state_q == REFILL_OK)),
    .upd_set(p_idx),
    .upd_way(plru_way)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_i) state_d = FLUSH_SCAN;
        else if (req && !hit) state_d = MISS;
      end
      MISS:      state_d = vic_dirty ? WRITEBACK : REFILL;
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        mem_enable_o = 1'b1;
        if (mem_ack_i) state_d = REFILL_OK;
      end
      REFILL_OK: state_d = IDLE;
      FLUSH_SCAN: begin
        if (fl_dirty) state_d = FLUSH_WB;
        else if (fl_last) state_d = IDLE;
      end
      FLUSH_WB: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        if (mem_ack_i) state_d = fl_last ? IDLE : FLUSH_SCAN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
      victim_q     <= '0;
      set_cnt_q    <= '0;
      way_cnt_q    <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= ((state_q == FLUSH_SCAN) && !fl_dirty && fl_last) ||
                      ((state_q == FLUSH_WB) && mem_ack_i && fl_last);
      case (state_q)
        IDLE: begin
          set_cnt_q <= '0;
          way_cnt_q <= '0;
          if (p1_MemWrite_i && hit) dirty_q[p_idx][hit_way] <= 1'b1;
        end
        MISS: begin
          victim_q <= victim;
          if (vic_dirty) begin
            mem_addr_q <= {tag_q[p_idx][victim], p_idx, {OFF_W{1'b0}}};
            mem_data_q <= data_q[p_idx][victim];
          end else begin
            mem_addr_q <= {p_tag, p_idx, {OFF_W{1'b0}}};
          end
        end
        WRITEBACK: if (mem_ack_i) mem_addr_q <= {p_tag, p_idx, {OFF_W{1'b0}}};
        REFILL_OK: begin
          valid_q[p_idx][victim_q] <= 1'b1;
          dirty_q[p_idx][victim_q] <= 1'b0;
        end
        FLUSH_SCAN: begin
          if (fl_dirty) begin
            mem_addr_q <= {tag_q[set_cnt_q][way_cnt_q], set_cnt_q, {OFF_W{1'b0}}};
            mem_data_q <= data_q[set_cnt_q][way_cnt_q];
          end else begin
            set_cnt_q <= set_nxt;
            way_cnt_q <= way_nxt;
          end
        end
        FLUSH_WB: begin
          if (mem_ack_i) begin
            dirty_q[set_cnt_q][way_cnt_q] <= 1'b0;
            set_cnt_q <= set_nxt;
            way_cnt_q <= way_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage needs no reset: valid bits gate every use of it.
  always_ff @(posedge clk_i) begin
    if ((state_q == IDLE) && p1_MemWrite_i && hit)
      data_q[p_idx][hit_way][p_wsel*WORD_W +: WORD_W] <= p1_data_i;
    if ((state_q == REFILL) && mem_ack_i) refill_q <= mem_data_i;
    if (state_q == REFILL_OK) begin
      data_q[p_idx][victim_q] <= refill_q;
      tag_q[p_idx][victim_q]  <= p_tag;
    end
  end

endmodule
